rle_vli_coder: RTL and testbench

//  JPEG-style run-length/VLI symbol generator for one quantised, zig-zag ordered coefficient stream.

---
 rtl/rle_vli_coder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_rle_vli_coder.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_vli_coder.sv
// rle_vli_coder
//   JPEG-style run-length / VLI symbol generator for a single quantised,
//   zig-zag ordered coefficient stream. It sits between the quantiser and the
//   Huffman packer. One DC predictor is kept per colour component. The block
//   emits DC, AC, ZRL (sixteen zeros) and EOB symbols.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     coefficient valid
//   in_ready     coefficient accepted when in_valid && in_ready
//   in_data      signed coefficient, zig-zag order (index 0 is DC)
//   in_comp      component id, sampled only when the DC coefficient is accepted
//   dc_reset     restart marker, clears every DC predictor
//   out_valid    symbol valid
//   out_ready    symbol consumed when out_valid && out_ready
//   out_type     0=DC 1=AC 2=ZRL 3=EOB
//   out_run      zero run in front of an AC coefficient (15 for ZRL, else 0)
//   out_size     magnitude category
//   out_vli      VLI bits, right-aligned; bits at or above size are 0
//   out_comp     component of the block the symbol belongs to
//   dbg_state    current FSM state (0=DC 1=AC 2=ZRL)
//
// Handshake: both sides use strict valid/ready. A transfer happens on a rising
// edge where valid && ready are both high. in_ready never looks at in_valid.
// While out_valid is high and out_ready is low, every out_* signal holds its
// value. Output is a single registered slot. A symbol appears in the cycle
// after the accept that creates it. A pop and a new accept can happen in the
// same cycle.
module rle_vli_coder #(
    parameter int DATA_WIDTH = 11,
    parameter int NUM_COMP   = 3,
    parameter int BLOCK_LEN  = 64,
    localparam int DIFF_W    = DATA_WIDTH + 1,
    localparam int SIZE_W    = $clog2(DIFF_W + 1),
    localparam int COMP_W    = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [COMP_W-1:0]     in_comp,
    input  logic                  dc_reset,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_type,
    output logic [3:0]            out_run,
    output logic [SIZE_W-1:0]     out_size,
    output logic [DIFF_W-1:0]     out_vli,
    output logic [COMP_W-1:0]     out_comp,
    output logic [1:0]            dbg_state
);

    localparam int IDX_W = $clog2(BLOCK_LEN);

    localparam logic [1:0] T_DC  = 2'd0;
    localparam logic [1:0] T_AC  = 2'd1;
    localparam logic [1:0] T_ZRL = 2'd2;
    localparam logic [1:0] T_EOB = 2'd3;

    typedef enum logic [1:0] {
        S_DC  = 2'd0,
        S_AC  = 2'd1,
        S_ZRL = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [IDX_W-1:0]             run_q, run_d;
    logic [COMP_W-1:0]            comp_q, comp_d;
    logic [DATA_WIDTH-1:0]        pred_q [NUM_COMP];
    logic [DATA_WIDTH-1:0]        pred_d [NUM_COMP];
    logic [DATA_WIDTH-1:0]        hold_coef_q, hold_coef_d;
    logic                         hold_last_q, hold_last_d;

    logic                         out_valid_q, out_valid_d;
    logic [1:0]                   out_type_q, out_type_d;
    logic [3:0]                   out_run_q, out_run_d;
    logic [SIZE_W-1:0]            out_size_q, out_size_d;
    logic [DIFF_W-1:0]            out_vli_q, out_vli_d;
    logic [COMP_W-1:0]            out_comp_q, out_comp_d;

    logic                         slot_free;
    logic                         accept;
    logic                         last_idx;
    logic                         run_big;
    logic [COMP_W-1:0]            comp_sel;
    logic [DATA_WIDTH-1:0]        pred_sel;

    logic                         emit;
    logic [1:0]                   emit_type;
    logic [3:0]                   emit_run;
    logic [DIFF_W-1:0]            emit_val;
    logic [COMP_W-1:0]            emit_comp;
    logic [SIZE_W-1:0]            emit_size;

    // Magnitude category: the bit length of |v|.
    function automatic logic [SIZE_W-1:0] calc_size(input logic [DIFF_W-1:0] v);
        logic [DIFF_W-1:0] mag;
        mag       = v[DIFF_W-1] ? (~v + DIFF_W'(1)) : v;
        calc_size = '0;
        for (int b = 0; b < DIFF_W; b++) begin
            if (mag[b]) calc_size = SIZE_W'(b + 1);
        end
    endfunction

    // A negative value is sent as the low `size` bits of (v - 1), which is its
    // ones' complement.
    function automatic logic [DIFF_W-1:0] calc_vli(input logic [DIFF_W-1:0] v,
                                                   input logic [SIZE_W-1:0] size);
        logic [DIFF_W-1:0] mask;
        mask     = (DIFF_W'(1) << size) - DIFF_W'(1);
        calc_vli = v[DIFF_W-1] ? ((v - DIFF_W'(1)) & mask) : v;
    endfunction

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = ((state_q == S_DC) || (state_q == S_AC)) && slot_free;
    assign accept    = in_valid && in_ready;
    assign last_idx  = (idx_q == IDX_W'(BLOCK_LEN - 1));
    assign run_big   = (run_q >= IDX_W'(16));

    // An out-of-range component id falls back to predictor 0.
    always_comb begin
        comp_sel = in_comp;
        if (int'(in_comp) >= NUM_COMP) comp_sel = '0;
    end

    // A dc_reset that arrives together with the DC coefficient already
    // counts for that coefficient.
    assign pred_sel = dc_reset ? '0 : pred_q[comp_sel];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        run_d       = run_q;
        comp_d      = comp_q;
        pred_d      = pred_q;
        hold_coef_d = hold_coef_q;
        hold_last_d = hold_last_q;
        emit        = 1'b0;
        emit_type   = T_DC;
        emit_run    = 4'd0;
        emit_val    = '0;
        emit_comp   = comp_q;

        if (dc_reset) begin
            for (int k = 0; k < NUM_COMP; k++) pred_d[k] = '0;
        end

        if (accept) begin
            idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
            if (state_q == S_DC) begin
                comp_d           = comp_sel;
                emit_comp        = comp_sel;
                emit             = 1'b1;
                emit_type        = T_DC;
                emit_val         = {in_data[DATA_WIDTH-1], in_data}
                                 - {pred_sel[DATA_WIDTH-1], pred_sel};
                pred_d[comp_sel] = in_data;
                run_d            = '0;
                state_d          = S_AC;
            end else if (in_data == '0) begin
                run_d = run_q + IDX_W'(1);
                if (last_idx) begin
                    // A trailing zero run collapses into EOB, and any ZRLs
                    // it would have needed are dropped.
                    emit      = 1'b1;
                    emit_type = T_EOB;
                    run_d     = '0;
                    state_d   = S_DC;
                end
            end else if (!run_big) begin
                emit      = 1'b1;
                emit_type = T_AC;
                emit_run  = run_q[3:0];
                emit_val  = {in_data[DATA_WIDTH-1], in_data};
                run_d     = '0;
                if (last_idx) state_d = S_DC;
            end else begin
                // Park the coefficient while the ZRL symbols drain out.
                hold_coef_d = in_data;
                hold_last_d = last_idx;
                state_d     = S_ZRL;
            end
        end else if ((state_q == S_ZRL) && slot_free) begin
            emit = 1'b1;
            if (run_big) begin
                emit_type = T_ZRL;
                emit_run  = 4'd15;
                run_d     = run_q - IDX_W'(16);
            end else begin
                emit_type = T_AC;
                emit_run  = run_q[3:0];
                emit_val  = {hold_coef_q[DATA_WIDTH-1], hold_coef_q};
                run_d     = '0;
                state_d   = hold_last_q ? S_DC : S_AC;
            end
        end
    end

    assign emit_size = calc_size(emit_val);

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_type_d  = out_type_q;
        out_run_d   = out_run_q;
        out_size_d  = out_size_q;
        out_vli_d   = out_vli_q;
        out_comp_d  = out_comp_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_type_d  = emit_type;
            out_run_d   = emit_run;
            out_size_d  = emit_size;
            out_vli_d   = calc_vli(emit_val, emit_size);
            out_comp_d  = emit_comp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DC;
            idx_q       <= '0;
            run_q       <= '0;
            comp_q      <= '0;
            for (int k = 0; k < NUM_COMP; k++) pred_q[k] <= '0;
            hold_coef_q <= '0;
            hold_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_type_q  <= '0;
            out_run_q   <= '0;
            out_size_q  <= '0;
            out_vli_q   <= '0;
            out_comp_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            comp_q      <= comp_d;
            pred_q      <= pred_d;
            hold_coef_q <= hold_coef_d;
            hold_last_q <= hold_last_d;
            out_valid_q <= out_valid_d;
            out_type_q  <= out_type_d;
            out_run_q   <= out_run_d;
            out_size_q  <= out_size_d;
            out_vli_q   <= out_vli_d;
            out_comp_q  <= out_comp_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_type  = out_type_q;
    assign out_run   = out_run_q;
    assign out_size  = out_size_q;
    assign out_vli   = out_vli_q;
    assign out_comp  = out_comp_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rle_vli_coder.sv
// Bench for rle_vli_coder.
// The scoreboard queue holds packed symbols {type, run, size, vli, comp}.
// Directed blocks push hand-computed symbols.
// Random blocks push symbols from a per-block reference model.
// The monitor pops one entry on every output handshake.
module tb_rle_vli_coder;
  localparam int DW = 11;
  localparam int NC = 3;
  localparam int BL = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_comp;
  logic          dc_reset;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_type;
  logic [3:0]    out_run;
  logic [3:0]    out_size;
  logic [11:0]   out_vli;
  logic [1:0]    out_comp;
  logic [1:0]    dbg_state;

  rle_vli_coder #(.DATA_WIDTH(DW), .NUM_COMP(NC), .BLOCK_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_comp(in_comp), .dc_reset(dc_reset),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_run(out_run), .out_size(out_size), .out_vli(out_vli),
    .out_comp(out_comp), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q[$];
  int rdy_mode = 0;               // 0: always ready, 1: random, 2: held low
  int m_pred[NC];
  logic [DW-1:0] blk_coef[BL];
  bit blk_dcr[BL];
  logic [1:0] blk_comp;

  // ---------------- clock/reset helpers and sink ready ----------------
  always @(negedge clk) begin
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1'b0;
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [23:0] pack_sym(int t, int r, int s, int v, int c);
    return {2'(t), 4'(r), 4'(s), 12'(v), 2'(c)};
  endfunction

  task automatic push_h(input int t, input int r, input int s, input int v, input int c);
    exp_q.push_back(pack_sym(t, r, s, v, c));
  endtask

  // Symbol from a signed value: size is the bit length of |v|.
  // For a negative v, vli is the low size bits of v - 1.
  task automatic push_val(input int t, input int r, input int v, input int c);
    int mag;
    int s;
    int vli;
    mag = (v < 0) ? -v : v;
    s = 0;
    while ((mag >> s) != 0) s++;
    vli = (v >= 0) ? v : ((v - 1) & ((1 << s) - 1));
    push_h(t, r, s, vli, c);
  endtask

  // Reference model for one whole block. It always updates the predictors.
  // It queues symbols only when push is set.
  task automatic model_block(input bit push);
    int c;
    int run;
    int v;
    c = (blk_comp < 2'd3) ? int'(blk_comp) : 0;
    run = 0;
    for (int i = 0; i < BL; i++) begin
      if (blk_dcr[i]) for (int k = 0; k < NC; k++) m_pred[k] = 0;
      v = $signed(blk_coef[i]);
      if (i == 0) begin
        if (push) push_val(0, 0, v - m_pred[c], c);
        m_pred[c] = v;
      end else if (v == 0) begin
        run++;
        if (i == BL - 1 && push) push_h(3, 0, 0, 0, c);
      end else begin
        while (run >= 16) begin
          if (push) push_h(2, 15, 0, 0, c);
          run -= 16;
        end
        if (push) push_val(1, run, v, c);
        run = 0;
      end
    end
  endtask

  task automatic clear_block(input logic [1:0] comp);
    blk_comp = comp;
    for (int i = 0; i < BL; i++) begin
      blk_coef[i] = '0;
      blk_dcr[i] = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  // Call only just after a rising edge. The task returns 1 ns after the
  // rising edge on which the coefficient was accepted.
  task automatic send_coef(input logic [DW-1:0] d, input logic [1:0] c, input bit r);
    int waited;
    bit ok;
    waited = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_comp = c;
    dc_reset = r;
    while (!ok && waited < 300) begin
      @(negedge clk);
      #1;
      ok = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: coefficient %0d not accepted after %0d cycles", d, waited);
    end
  endtask

  task automatic send_block();
    @(posedge clk);
    #1;
    for (int i = 0; i < BL; i++)
      send_coef(blk_coef[i], (i == 0) ? blk_comp : 2'($urandom_range(0, 3)), blk_dcr[i]);
    in_valid = 1'b0;
    dc_reset = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d symbols still expected, 0 required", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [23:0] mon_got;
  logic [23:0] mon_exp;
  logic [23:0] prev_got;
  bit prev_stall = 1'b0;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      mon_got = {out_type, out_run, out_size, out_vli, out_comp};
      if (prev_stall) begin
        n_checks++;
        if (mon_got !== prev_got) begin
          n_errors++;
          $display("FAIL hold_stable: got %h while stalled, required %h", mon_got, prev_got);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_symbol: got %h, no symbol expected", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_errors++;
            $display("FAIL symbol: got type=%0d run=%0d size=%0d vli=%0h comp=%0d, expected type=%0d run=%0d size=%0d vli=%0h comp=%0d",
                     mon_got[23:22], mon_got[21:18], mon_got[17:14], mon_got[13:2], mon_got[1:0],
                     mon_exp[23:22], mon_exp[21:18], mon_exp[17:14], mon_exp[13:2], mon_exp[1:0]);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_got = mon_got;
    end
  end

  // Watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int dens;
    bit found;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_comp = '0;
    dc_reset = 1'b0;
    for (int k = 0; k < NC; k++) m_pred[k] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_type", out_type, 0);
    check("reset_out_run", out_run, 0);
    check("reset_out_size", out_size, 0);
    check("reset_out_vli", out_vli, 0);
    check("reset_out_comp", out_comp, 0);
    check("reset_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready_after_reset", in_ready, 1);

    // Test 1: DC 100 with all-zero AC, then DC 90 (diff -10).
    clear_block(2'd0); blk_coef[0] = 11'd100;
    push_h(0, 0, 7, 100, 0); push_h(3, 0, 0, 0, 0);
    model_block(0); send_block();
    clear_block(2'd0); blk_coef[0] = 11'd90;
    push_h(0, 0, 4, 5, 0); push_h(3, 0, 0, 0, 0);
    model_block(0); send_block();
    drain();

    // Test 2: 40 zeros, then 3 at index 41 -> ZRL, ZRL, AC r8.
    clear_block(2'd2); blk_coef[41] = 11'd3;
    push_h(0, 0, 0, 0, 2); push_h(2, 15, 0, 0, 2); push_h(2, 15, 0, 0, 2);
    push_h(1, 8, 2, 3, 2); push_h(3, 0, 0, 0, 2);
    model_block(0); send_block();

    // Test 3: -1 at the last index after 20 zeros gives no EOB.
    clear_block(2'd2); blk_coef[42] = 11'd1; blk_coef[63] = -11'sd1;
    push_h(0, 0, 0, 0, 2); push_h(2, 15, 0, 0, 2); push_h(2, 15, 0, 0, 2);
    push_h(1, 9, 1, 1, 2); push_h(2, 15, 0, 0, 2); push_h(1, 4, 1, 0, 2);
    model_block(0); send_block();
    drain();

    // Test 4: independent predictors. The first DC carries dc_reset.
    clear_block(2'd0); blk_coef[0] = 11'd50; blk_dcr[0] = 1'b1;
    push_h(0, 0, 6, 50, 0); push_h(3, 0, 0, 0, 0);
    model_block(0); send_block();
    clear_block(2'd1); blk_coef[0] = 11'd50;
    push_h(0, 0, 6, 50, 1); push_h(3, 0, 0, 0, 1);
    model_block(0); send_block();
    clear_block(2'd0); blk_coef[0] = 11'd52;
    push_h(0, 0, 2, 2, 0); push_h(3, 0, 0, 0, 0);
    model_block(0); send_block();
    drain();

    // Test 5: the sink stalls in the middle of a ZRL flush.
    clear_block(2'd1); blk_coef[0] = 11'd60; blk_coef[41] = -11'sd3;
    push_h(0, 0, 4, 10, 1); push_h(2, 15, 0, 0, 1); push_h(2, 15, 0, 0, 1);
    push_h(1, 8, 2, 0, 1); push_h(3, 0, 0, 0, 1);
    model_block(0);
    fork
      send_block();
      begin
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
          @(posedge clk);
          #1;
          if (dbg_state == 2'd2) found = 1'b1;
        end
        check("zrl_state_reached", found, 1);
        rdy_mode = 2;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          #1;
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          check("stall_out_type_zrl", out_type, 2);
        end
        rdy_mode = 0;
      end
    join
    drain();

    // Extreme values: largest positive and negative diffs, and AC -1024.
    clear_block(2'd1); blk_coef[0] = 11'd1023; blk_coef[1] = -11'sd1024;
    push_h(0, 0, 10, 963, 1); push_h(1, 0, 11, 1023, 1); push_h(3, 0, 0, 0, 1);
    model_block(0); send_block();
    clear_block(2'd1); blk_coef[0] = -11'sd1024;
    push_h(0, 0, 11, 0, 1); push_h(3, 0, 0, 0, 1);
    model_block(0); send_block();
    clear_block(2'd1); blk_coef[0] = 11'd1023; blk_coef[63] = 11'd1023;
    push_h(0, 0, 11, 2047, 1); push_h(2, 15, 0, 0, 1); push_h(2, 15, 0, 0, 1);
    push_h(2, 15, 0, 0, 1); push_h(1, 14, 10, 1023, 1);
    model_block(0); send_block();
    drain();

    // Test 6a: dc_reset in the middle of a block; the next DC is coded against 0.
    clear_block(2'd1); blk_coef[0] = 11'd20; blk_dcr[5] = 1'b1;
    push_h(0, 0, 10, 20, 1); push_h(3, 0, 0, 0, 1);
    model_block(0); send_block();
    clear_block(2'd1); blk_coef[0] = 11'd20;
    push_h(0, 0, 5, 20, 1); push_h(3, 0, 0, 0, 1);
    model_block(0); send_block();
    drain();

    // Test 6b: rst_n in the middle of a block while a symbol waits in the slot.
    push_h(0, 0, 6, 33, 2);
    @(posedge clk);
    #1;
    send_coef(11'd33, 2'd2, 1'b0);
    send_coef(11'd0, 2'd1, 1'b0);
    send_coef(11'd0, 2'd3, 1'b0);
    send_coef(11'd0, 2'd0, 1'b0);
    in_valid = 1'b0;
    drain();
    rdy_mode = 2;
    send_coef(11'd7, 2'd0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pre_reset_out_valid", out_valid, 1);
    check("pre_reset_out_run", out_run, 3);
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", out_valid, 0);
    check("mid_reset_out_vli", out_vli, 0);
    check("mid_reset_state", dbg_state, 0);
    for (int k = 0; k < NC; k++) m_pred[k] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    #1;
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_state", dbg_state, 0);
    clear_block(2'd2); blk_coef[0] = -11'sd3;
    push_h(0, 0, 2, 0, 2); push_h(3, 0, 0, 0, 2);
    model_block(0); send_block();
    clear_block(2'd1); blk_coef[0] = 11'd20;
    push_h(0, 0, 5, 20, 1); push_h(3, 0, 0, 0, 1);
    model_block(0); send_block();
    drain();

    // Random blocks with a random sink, checked against the reference model.
    rdy_mode = 1;
    for (int b = 0; b < 200; b++) begin
      clear_block(2'($urandom_range(0, 3)));
      blk_coef[0] = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 9) == 0) blk_dcr[0] = 1'b1;
      dens = $urandom_range(0, 3);
      for (int i = 1; i < BL; i++) begin
        if (dens != 0 && $urandom_range(0, 4 * dens) == 0) begin
          if ($urandom_range(0, 7) == 0) blk_coef[i] = 11'($urandom_range(1, 2047));
          else blk_coef[i] = 11'(int'($urandom_range(0, 30)) - 15);
        end
        if ($urandom_range(0, 299) == 0) blk_dcr[i] = 1'b1;
      end
      model_block(1);
      send_block();
    end
    drain();
    rdy_mode = 0;

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover_expected: %0d symbols never seen, 0 required", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
